// File: rtl/squeeze_bias_relu_pkg.sv
// Shared constants, types and the bias format helper for the fire3 squeeze
// post-accumulation stage.
package squeeze_pkg;

  localparam int NUM_CH     = 16;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int B_W        = 16;
  localparam int FRAC_SHIFT = 8;
  localparam logic [OUT_W-1:0] ACT_MAX = 16'h7FFF;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [OUT_W-1:0]        act_t;

  // Bias ROM word: sign-magnitude Q8.8
  typedef struct packed {
    logic           sign;
    logic [B_W-2:0] mag;
  } bias_sm_t;

  // Sign-magnitude to two's complement; negative zero maps to 0
  function automatic logic signed [B_W-1:0] sm_to_tc(bias_sm_t b);
    logic signed [B_W-1:0] m;
    m = $signed({1'b0, b.mag});
    return b.sign ? -m : m;
  endfunction

endpackage

// File: rtl/squeeze_bias_relu_if.sv
// Accumulator-in / activation-out handshake bundle for squeeze_bias_relu.
interface squeeze_bias_relu_if;
  import squeeze_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_CH-1:0][ACC_W-1:0] in_acc;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_CH-1:0][OUT_W-1:0] out_act;
  logic                        out_last;
  logic                        frame_done;

  // The stage itself
  modport slave (
    input  in_valid, in_acc, out_ready,
    output in_ready, out_valid, out_act, out_last, frame_done
  );

  // Producer of accumulators / consumer of activations
  modport master (
    output in_valid, in_acc, out_ready,
    input  in_ready, out_valid, out_act, out_last, frame_done
  );

endinterface

// File: rtl/squeeze_bias_lane.sv
// One channel of the bias/ReLU/saturate datapath: stage-1 bias add,
// stage-2 rescale, ReLU and clamp. Both registers share the pipeline enable.
module squeeze_bias_lane
  import squeeze_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  input  acc_t     acc_i,
  input  bias_sm_t bias_i,
  output act_t     act_o
);

  // One extra bit so acc + bias never overflows
  localparam int SUM_W = ACC_W + 1;

  logic signed [B_W-1:0]   bias_tc;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic signed [SUM_W-1:0] shr;
  act_t                    act_d, act_q;

  // Stage 1: Q8.8 bias aligned to the Q.16 accumulator, then added
  always_comb begin
    bias_tc = sm_to_tc(bias_i);
    sum_d   = $signed({acc_i[ACC_W-1], acc_i})
            + $signed({{(SUM_W-B_W-FRAC_SHIFT){bias_tc[B_W-1]}}, bias_tc, {FRAC_SHIFT{1'b0}}});
  end

  // Stage 2: floor rescale to Q8.8, negative -> 0, above 0x7FFF -> clamp
  always_comb begin
    shr = sum_q >>> FRAC_SHIFT;
    if (shr[SUM_W-1])                 act_d = '0;
    else if (|shr[SUM_W-2:OUT_W-1])   act_d = ACT_MAX;
    else                              act_d = shr[OUT_W-1:0];
  end

  // Both stage registers advance together when the pipe is not stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      act_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
      act_q <= act_d;
    end
  end

  assign act_o = act_q;

endmodule

// File: rtl/squeeze_bias_relu.sv
// fire3 squeeze post-accumulation: per-channel bias, ReLU, Q8.8 saturate,
// 2-stage pipeline with frame pixel tracking and last-pixel flagging.
module squeeze_bias_relu
  import squeeze_pkg::*;
#(
  parameter int FRAME_PIXELS = 3025
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  bias_sm_t [NUM_CH-1:0]   bias_mem,
  squeeze_bias_relu_if.slave      bus
);

  localparam int STAGES = 2;
  localparam int CNT_W  = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  logic                         en;
  logic                         accept;
  logic                         out_hs;
  logic [STAGES:1]              vld_pipe_q;
  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic                         last_d, last_q;
  logic                         frame_done_q;
  logic [NUM_CH-1:0][OUT_W-1:0] act_vec;

  // Whole pipe advances unless the output beat is held by backpressure
  always_comb begin
    en     = !vld_pipe_q[STAGES] || bus.out_ready;
    out_hs = vld_pipe_q[STAGES] && bus.out_ready;
    accept = bus.in_valid && bus.in_ready;
  end

  assign bus.in_ready = en && rst_n;

  // Pixel counter and the index of the pixel moving into stage 2: after this
  // edge the stage-2 pixel is exactly the next one to be emitted, i.e. cnt_d
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    last_d = vld_pipe_q[1] && (cnt_d == LAST_IDX);
  end

  // Valid shift register, stage-aligned last flag, counter, frame pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q   <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= out_hs && last_q;
      if (en) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], accept};
        last_q     <= last_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    squeeze_bias_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .acc_i  (bus.in_acc[g]),
      .bias_i (bias_mem[g]),
      .act_o  (act_vec[g])
    );
  end

  assign bus.out_valid  = vld_pipe_q[STAGES];
  assign bus.out_act    = act_vec;
  assign bus.out_last   = last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_squeeze_bias_relu.sv
// Randomized self-checking bench for squeeze_bias_relu with a queue-based
// arithmetic reference model.
module tb_squeeze_bias_relu;
  import squeeze_pkg::*;

  localparam int FP = 3025;
  typedef logic [NUM_CH-1:0][OUT_W-1:0] vec_t;
  typedef logic [NUM_CH-1:0][ACC_W-1:0] accv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0][B_W-1:0] bias;

  squeeze_bias_relu_if bus();

  squeeze_bias_relu #(.FRAME_PIXELS(FP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bias_mem (bias),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t expq[$];
  int   pix_idx = 0;
  bit   fd_exp = 1'b0;
  int   fd_seen = 0;
  int   frames_exp = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bias in real terms, added to the accumulator, floor to Q8.8, ReLU, clamp
  function automatic logic [15:0] ref_act(input logic [31:0] a, input logic [15:0] b);
    longint s, bt;
    bt = longint'(b[14:0]);
    if (b[15]) bt = -bt;
    s = longint'($signed(a)) + bt * 256;
    s = s >>> 8;
    if (s < 0) return 16'h0000;
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  function automatic vec_t ref_vec(input accv_t acc);
    vec_t v;
    for (int i = 0; i < NUM_CH; i++) v[i] = ref_act(acc[i], bias[i]);
    return v;
  endfunction

  function automatic accv_t rand_vec();
    accv_t v;
    for (int i = 0; i < NUM_CH; i++) begin
      case ($urandom % 4)
        0: v[i] = $urandom;
        1: v[i] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
        2: v[i] = 32'h7FFF_0000 ^ ($urandom & 32'hFFFF);
        default: v[i] = $urandom_range(0, 32'h0100_0000);
      endcase
    end
    return v;
  endfunction

  // One clock: inputs already set at this negedge; predict, then advance
  task automatic step(output bit accepted);
    vec_t e;
    bit   fd_next;
    #1;
    accepted = 1'b0;
    fd_next  = 1'b0;
    chk("frame_done", 256'(bus.frame_done), 256'(fd_exp));
    if (bus.frame_done) fd_seen++;
    if (!rst_n) begin
      expq.delete();
      pix_idx = 0;
    end else begin
      if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", 256'(bus.in_ready), 256'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 256'(1), 256'(0));
        end else begin
          e = expq.pop_front();
          chk("out_act", 256'(bus.out_act), 256'(e));
          chk("out_last", 256'(bus.out_last), 256'(pix_idx == FP - 1));
          if (pix_idx == FP - 1) begin
            fd_next = 1'b1;
            frames_exp++;
          end
          pix_idx = (pix_idx == FP - 1) ? 0 : pix_idx + 1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_vec(bus.in_acc));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    fd_exp = fd_next;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    bit a;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && expq.size() > 0; k++) step(a);
    chk(tag, 256'(expq.size()), 256'(0));
  endtask

  initial begin
    bit    a;
    int    sent;
    accv_t d;

    for (int i = 0; i < NUM_CH; i++) bias[i] = 16'($urandom);
    bias[0] = 16'h021B;
    bias[1] = 16'h8021;
    bias[2] = 16'h8000;
    bias[3] = 16'h0160;
    bias[7] = 16'h82CF;
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    step(a);
    step(a);
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_act", 256'(bus.out_act), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst_out_last", 256'(bus.out_last), 256'(0));
    rst_n = 1'b1;
    step(a);

    // Directed pixel: bias add, ReLU, negative-zero, saturation, min acc
    d = rand_vec();
    d[0] = 32'h0000_0000;
    d[1] = 32'h0001_0000;
    d[2] = 32'h0000_0100;
    d[3] = 32'h7FFF_0000;
    d[4] = 32'h8000_0000;
    d[7] = 32'h0001_0000;
    bus.in_acc   = d;
    bus.in_valid = 1'b1;
    step(a);
    chk("dir_accept", 256'(a), 256'(1));
    bus.in_valid = 1'b0;
    chk("lat1_valid", 256'(bus.out_valid), 256'(0));
    step(a);
    chk("lat2_valid", 256'(bus.out_valid), 256'(1));
    chk("ch0_bias", 256'(bus.out_act[0]), 256'(16'h021B));
    chk("ch1_negbias", 256'(bus.out_act[1]), 256'(16'h00DF));
    chk("ch2_negzero", 256'(bus.out_act[2]), 256'(16'h0001));
    chk("ch3_sat", 256'(bus.out_act[3]), 256'(16'h7FFF));
    chk("ch4_minacc", 256'(bus.out_act[4]), 256'(16'h0000));
    chk("ch7_relu", 256'(bus.out_act[7]), 256'(16'h0000));
    step(a);
    drain("dir_drain");

    // Four back-to-back pixels with out_ready low for cycles 3..5
    sent = 0;
    for (int k = 0; k < 30 && (sent < 4 || expq.size() > 0); k++) begin
      bus.in_valid  = (sent < 4);
      bus.in_acc    = rand_vec();
      bus.out_ready = !(k >= 3 && k <= 5);
      step(a);
      if (a) sent++;
    end
    chk("stall_sent", 256'(sent), 256'(4));
    drain("stall_drain");

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_acc    = rand_vec();
      bus.out_ready = ($urandom % 3) != 0;
      step(a);
    end
    drain("rand_drain");

    // Fresh frame: full stream, last flag and frame_done at pixel FP-1
    rst_n = 1'b0;
    step(a);
    rst_n = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < FP + 6; k++) begin
      bus.in_acc = rand_vec();
      step(a);
    end

    // Reset with pixels in flight: they vanish and the count restarts
    rst_n = 1'b0;
    step(a);
    chk("rstfl_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rstfl_out_act", 256'(bus.out_act), 256'(0));
    rst_n = 1'b1;
    for (int k = 0; k < FP + 4; k++) begin
      bus.in_acc = rand_vec();
      step(a);
    end
    drain("frame_drain");
    step(a);
    chk("frames_model", 256'(frames_exp), 256'(2));
    chk("frame_done_count", 256'(fd_seen), 256'(frames_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
